// File: rtl/gradient_pkg.sv
// Shared types and defaults for the gradient (Gx/Gy) front end.
package gradient_pkg;

   // Frame sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_ACTIVE   = 2'd2
   } ctrl_state_t;

   // Default geometry and pixel width (packed Gx[15:0] / Gy[31:16]).
   localparam int N_DEF      = 32;
   localparam int WIDTH_DEF  = 355;
   localparam int HEIGHT_DEF = 355;

   // Coordinate counter width: enough bits for the larger dimension, never zero.
   function automatic int COORD_W(input int w, input int h);
      int m;
      m = (w > h) ? w : h;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Pixel/line position counter for a WIDTH x HEIGHT raster.
// pix/line are the registered position of the next expected beat. eol/eof
// describe the beat currently presented, which is taken to be at the origin
// when load_origin is set (start-of-frame resynchronisation). Shared with
// the capture side, so it carries no knowledge of the controller states.
module frame_pos_counter
   import gradient_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int CW     = COORD_W(WIDTH, HEIGHT)
) (
   input  logic          i_sys_clk,
   input  logic          i_sys_aresetn,
   input  logic          en,
   input  logic          clr,
   input  logic          load_origin,
   output logic          eol,
   output logic          eof,
   output logic [CW-1:0] pix,
   output logic [CW-1:0] line
);

   localparam logic [CW-1:0] PIX_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LINE_LAST = CW'(HEIGHT - 1);

   logic [CW-1:0] base_pix;
   logic [CW-1:0] base_line;

   // Position of the beat being presented: origin on resync, else the count.
   always_comb begin
      base_pix  = load_origin ? '0 : pix;
      base_line = load_origin ? '0 : line;
   end

   assign eol = (base_pix == PIX_LAST);
   assign eof = eol && (base_line == LINE_LAST);

   // Advance one raster position per counted beat; wrap at end of frame.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         pix  <= '0;
         line <= '0;
      end else if (clr) begin
         pix  <= '0;
         line <= '0;
      end else if (en) begin
         if (eol) begin
            pix  <= '0;
            line <= (base_line == LINE_LAST) ? '0 : base_line + CW'(1);
         end else begin
            pix  <= base_pix + CW'(1);
            line <= base_line;
         end
      end
   end

endmodule

// File: rtl/gradient_frame_ctrl.sv
// Frame sequencer in front of the gradient datapath: gates the incoming
// video stream into whole frames on command, regenerates tuser/tlast from
// its own position count, flags geometry errors and counts finished frames.
//
// Stream handshake: a beat transfers in every cycle with tvalid=1. There is
// no tready in either direction, so nothing stalls; beats the sequencer does
// not want are dropped, and o_video_tvalid marks each forwarded beat exactly
// one cycle after it arrived.
module gradient_frame_ctrl
   import gradient_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic         i_sys_clk,
   input  logic         i_sys_aresetn,
   input  logic         i_start,
   input  logic         i_continuous,
   input  logic         i_abort,
   input  logic [N-1:0] i_video_tdata,
   input  logic         i_video_tvalid,
   input  logic         i_video_tlast,
   input  logic         i_video_tuser,
   output logic [N-1:0] o_video_tdata,
   output logic         o_video_tvalid,
   output logic         o_video_tlast,
   output logic         o_video_tuser,
   output logic         o_busy,
   output logic         o_frame_done,
   output logic [15:0]  o_frame_count,
   output logic         o_err_line,
   output logic         o_err_sof,
   output ctrl_state_t  o_state
);

   localparam int CW = COORD_W(WIDTH, HEIGHT);

   ctrl_state_t   state;
   ctrl_state_t   state_nxt;
   logic          cont_q;
   logic          fwd;
   logic          cnt_clr;
   logic          cnt_load;
   logic          resync;
   logic          done;
   logic          clr_err;
   logic          latch_cont;
   logic          eol;
   logic          eof;
   logic          at_origin;
   logic [CW-1:0] pix;
   logic [CW-1:0] line;
   logic [15:0]   frame_count;

   frame_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .CW     (CW)
   ) u_pos (
      .i_sys_clk     (i_sys_clk),
      .i_sys_aresetn (i_sys_aresetn),
      .en            (fwd),
      .clr           (cnt_clr),
      .load_origin   (cnt_load),
      .eol           (eol),
      .eof           (eof),
      .pix           (pix),
      .line          (line)
   );

   // Registered count sitting at (0,0) means the next beat opens the frame.
   assign at_origin = (pix == '0) && (line == '0);

   // State register.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   // Next state and per-beat control strobes; abort overrides everything.
   always_comb begin
      state_nxt  = state;
      fwd        = 1'b0;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      resync     = 1'b0;
      done       = 1'b0;
      clr_err    = 1'b0;
      latch_cont = 1'b0;
      if (i_abort) begin
         state_nxt = ST_IDLE;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state_nxt  = ST_WAIT_SOF;
                  clr_err    = 1'b1;
                  latch_cont = 1'b1;
                  cnt_clr    = 1'b1;
               end
            end
            ST_WAIT_SOF: begin
               if (i_video_tvalid && i_video_tuser) begin
                  fwd       = 1'b1;
                  cnt_load  = 1'b1;
                  state_nxt = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (i_video_tvalid) begin
                  fwd = 1'b1;
                  // A start-of-frame away from the origin restarts the frame here.
                  if (i_video_tuser && !at_origin) begin
                     resync   = 1'b1;
                     cnt_load = 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
         if (fwd && eof) begin
            done      = 1'b1;
            state_nxt = cont_q ? ST_WAIT_SOF : ST_IDLE;
         end
      end
   end

   // Continuous-mode latch, captured with the accepted start command.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn)  cont_q <= 1'b0;
      else if (latch_cont) cont_q <= i_continuous;
   end

   // Sticky geometry error flags, cleared by each accepted start.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         o_err_line <= 1'b0;
         o_err_sof  <= 1'b0;
      end else if (clr_err) begin
         o_err_line <= 1'b0;
         o_err_sof  <= 1'b0;
      end else begin
         if (fwd && (i_video_tlast != eol)) o_err_line <= 1'b1;
         if (resync)                        o_err_sof  <= 1'b1;
      end
   end

   // One-cycle output register with regenerated sideband and frame pulse.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         o_video_tdata  <= '0;
         o_video_tvalid <= 1'b0;
         o_video_tlast  <= 1'b0;
         o_video_tuser  <= 1'b0;
         o_frame_done   <= 1'b0;
      end else begin
         o_video_tvalid <= fwd;
         o_video_tlast  <= fwd && eol;
         o_video_tuser  <= fwd && (cnt_load || at_origin);
         o_frame_done   <= done;
         if (fwd) o_video_tdata <= i_video_tdata;
      end
   end

   // Completed-frame counter; wraps naturally at 16 bits.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) frame_count <= '0;
      else if (done)      frame_count <= frame_count + 16'd1;
   end

   assign o_frame_count = frame_count;
   assign o_busy        = (state != ST_IDLE);
   assign o_state       = state;

endmodule
